reg_wb_queue: RTL and testbench
===============================

// Module: reg_wb_queue
// PURPOSE
//   Write-back side of the register file: collects results from the ALU and
//   load paths, queues them in program order and drains one write per cycle
//   into the regfile write port (regWr/RegW/WriteDat). A 2-port lookup lets
//   decode read in-flight results before they reach the regfile.
// PARAMETERS
//   DEPTH  4  queue entries; power of two, >= 2
//   AW     2  log2(DEPTH); pointer width (count is AW+1 bits)
// PORTS
//   clk        in   1   clock, all state on rising edge
//   rst_n      in   1   asynchronous active-low reset
//   mem_valid  in   1   load result offered this cycle
//   mem_reg    in   5   load destination register
//   mem_dat    in   32  load data
//   alu_valid  in   1   ALU result offered this cycle
//   alu_reg    in   5   ALU destination register
//   alu_dat    in   32  ALU data
//   stall      out  1   queue cannot take two entries; producers must hold
//   regWr      out  1   regfile write enable
//   RegW       out  5   regfile write address
//   WriteDat   out  32  regfile write data
//   RegR1      in   5   lookup address, port 1
//   RegR2      in   5   lookup address, port 2
//   fwd1_hit   out  1   RegR1 has a pending queued write
//   fwd1_dat   out  32  youngest queued data for RegR1
//   fwd2_hit   out  1   RegR2 has a pending queued write
//   fwd2_dat   out  32  youngest queued data for RegR2
// BEHAVIOUR
//   - Reset (async, rst_n=0): head/tail pointers and count cleared; regWr=0,
//     stall=0, fwd*_hit=0 immediately. Reset mid-drain discards all entries.
//   - stall = (count > DEPTH-2), from registered count only; reset value 0.
//   - Enqueue (stall=0): valid offers with reg!=0 are written at tail. If both
//     mem and alu are valid, mem is written first (older), alu second; tail
//     advances by 0/1/2 and wraps mod DEPTH. Writes to reg 0 are dropped.
//     When stall=1 all offers are ignored (nothing enqueued).
//   - Drain: regWr=(count!=0); RegW/WriteDat = head entry, combinational
//     from queue state. Head pops on every edge where count!=0 (regfile
//     always accepts). When count=0, RegW=0 and WriteDat=0.
//   - Push and pop in the same cycle: count_next = count + pushes - pop;
//     count never exceeds DEPTH, never underflows.
//   - Latency: an entry pushed into an empty queue appears on regWr the
//     next cycle; it is written to the regfile on the following edge.
//   - Lookup: combinational over valid entries only (head..tail-1, including
//     the head being written this cycle). Youngest match wins. RegRx=0
//     never hits. Same-cycle incoming offers are not visible to lookup.
// TESTING (DEPTH=4)
//   1 Reset, mem_valid=1 reg=5 dat=0xAAAA0001 one cycle -> next cycle regWr=1
//     RegW=5 WriteDat=0xAAAA0001; following cycle regWr=0.
//   2 mem(reg 3,0x11) + alu(reg 4,0x22) same cycle -> RegW=3 then RegW=4 on
//     consecutive cycles; stall stays 0.
//   3 Two dual-offer cycles back-to-back -> stall=1 after second (count=3);
//     third offer ignored; stall drops once count<=2.
//   4 Queue reg 7=0x1, then reg 7=0x2 -> RegR1=7 gives fwd1_hit=1
//     fwd1_dat=0x2; after both drain fwd1_hit=0.
//   5 alu_valid with alu_reg=0 -> nothing queued, regWr stays 0;
//     RegR2=0 -> fwd2_hit=0.
//   6 rst_n low while count=3 -> regWr=0, stall=0 at once; no writes after.

Source files
------------

// File: rtl/reg_wb_queue.sv
// rtl/reg_wb_queue.sv - in-order write-back queue feeding the regfile write port
// Also gives decode a two-port forwarding lookup over the results still queued.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_dat,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_dat,
  output logic        stall,
  output logic        regWr,
  output logic [4:0]  RegW,
  output logic [31:0] WriteDat,
  input  logic [4:0]  RegR1,
  input  logic [4:0]  RegR2,
  output logic        fwd1_hit,
  output logic [31:0] fwd1_dat,
  output logic        fwd2_hit,
  output logic [31:0] fwd2_dat
);

  logic [4:0]    regQ [DEPTH];
  logic [31:0]   datQ [DEPTH];
  logic [AW-1:0] headPtr;
  logic [AW-1:0] tailPtr;
  logic [AW:0]   count;

  logic          memPush;
  logic          aluPush;
  logic          pop;
  logic [AW-1:0] aluSlot;

  // Stall looks only at registered count so producers see a glitch-free hold.
  assign stall   = count > (AW+1)'(DEPTH - 2);
  assign memPush = mem_valid && (mem_reg != 5'd0) && !stall;
  assign aluPush = alu_valid && (alu_reg != 5'd0) && !stall;
  assign pop     = count != '0;
  // The load result is older, so it takes the tail slot and ALU lands behind it.
  assign aluSlot = tailPtr + AW'(memPush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (pop) headPtr <= headPtr + AW'(1);
      tailPtr <= tailPtr + AW'(memPush) + AW'(aluPush);
      count   <= count + (AW+1)'(memPush) + (AW+1)'(aluPush) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (memPush) begin
      regQ[tailPtr] <= mem_reg;
      datQ[tailPtr] <= mem_dat;
    end
    if (aluPush) begin
      regQ[aluSlot] <= alu_reg;
      datQ[aluSlot] <= alu_dat;
    end
  end

  assign regWr    = pop;
  assign RegW     = pop ? regQ[headPtr] : 5'd0;
  assign WriteDat = pop ? datQ[headPtr] : 32'd0;

  // Walk oldest to youngest so the last match (the youngest) wins.
  always_comb begin
    fwd1_hit = 1'b0;
    fwd1_dat = 32'd0;
    fwd2_hit = 1'b0;
    fwd2_dat = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((AW+1)'(i) < count) begin
        if (RegR1 != 5'd0 && regQ[headPtr + AW'(i)] == RegR1) begin
          fwd1_hit = 1'b1;
          fwd1_dat = datQ[headPtr + AW'(i)];
        end
        if (RegR2 != 5'd0 && regQ[headPtr + AW'(i)] == RegR2) begin
          fwd2_hit = 1'b1;
          fwd2_dat = datQ[headPtr + AW'(i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_queue.sv
// tb/tb_reg_wb_queue.sv - directed vector bench for reg_wb_queue
// Inputs change on the falling edge and outputs are sampled 1ns later.
module tb_reg_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic [4:0]  mem_reg;
  logic [31:0] mem_dat;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_dat;
  logic        stall;
  logic        regWr;
  logic [4:0]  RegW;
  logic [31:0] WriteDat;
  logic [4:0]  RegR1;
  logic [4:0]  RegR2;
  logic        fwd1_hit;
  logic [31:0] fwd1_dat;
  logic        fwd2_hit;
  logic [31:0] fwd2_dat;

  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  reg_wb_queue #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_dat(mem_dat),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_dat(alu_dat),
    .stall(stall), .regWr(regWr), .RegW(RegW), .WriteDat(WriteDat),
    .RegR1(RegR1), .RegR2(RegR2),
    .fwd1_hit(fwd1_hit), .fwd1_dat(fwd1_dat),
    .fwd2_hit(fwd2_hit), .fwd2_dat(fwd2_dat)
  );

  typedef struct {
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        eStall;
    logic        eWr;
    logic [4:0]  eRegW;
    logic [31:0] eDat;
    logic        eH1;
    logic [31:0] eD1;
    logic        eH2;
    logic [31:0] eD2;
  } vec_t;

  function automatic vec_t mk(
    logic mv, logic [4:0] mr, logic [31:0] md,
    logic av, logic [4:0] ar, logic [31:0] ad,
    logic [4:0] r1, logic [4:0] r2,
    logic eStall, logic eWr, logic [4:0] eRegW, logic [31:0] eDat,
    logic eH1, logic [31:0] eD1, logic eH2, logic [31:0] eD2);
    vec_t v;
    v.mv = mv; v.mr = mr; v.md = md; v.av = av; v.ar = ar; v.ad = ad;
    v.r1 = r1; v.r2 = r2; v.eStall = eStall; v.eWr = eWr; v.eRegW = eRegW;
    v.eDat = eDat; v.eH1 = eH1; v.eD1 = eD1; v.eH2 = eH2; v.eD2 = eD2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    mem_valid = mv; mem_reg = mr; mem_dat = md;
    alu_valid = av; alu_reg = ar; alu_dat = ad;
    RegR1 = r1; RegR2 = r2;
    #1;
  endtask

  vec_t vecs[17];

  initial begin
    rst_n = 1'b0;
    mem_valid = 1'b0; mem_reg = 5'd0; mem_dat = 32'd0;
    alu_valid = 1'b0; alu_reg = 5'd0; alu_dat = 32'd0;
    RegR1 = 5'd0; RegR2 = 5'd0;

    // Outputs expected on the sampled cycle; state reflects earlier rows only.
    vecs[0]  = mk(0,0,0,          0,0,0,           0,0, 0,0,0,0,           0,0,           0,0);
    vecs[1]  = mk(1,5,32'hAAAA0001,0,0,0,          0,0, 0,0,0,0,           0,0,           0,0);
    vecs[2]  = mk(0,0,0,          0,0,0,           5,0, 0,1,5,32'hAAAA0001,1,32'hAAAA0001,0,0);
    vecs[3]  = mk(0,0,0,          0,0,0,           5,0, 0,0,0,0,           0,0,           0,0);
    vecs[4]  = mk(1,3,32'h11,     1,4,32'h22,      0,0, 0,0,0,0,           0,0,           0,0);
    vecs[5]  = mk(0,0,0,          0,0,0,           3,4, 0,1,3,32'h11,      1,32'h11,      1,32'h22);
    vecs[6]  = mk(0,0,0,          0,0,0,           3,4, 0,1,4,32'h22,      0,0,           1,32'h22);
    vecs[7]  = mk(0,0,0,          0,0,0,           3,4, 0,0,0,0,           0,0,           0,0);
    vecs[8]  = mk(1,7,32'h1,      1,7,32'h2,       7,0, 0,0,0,0,           0,0,           0,0);
    vecs[9]  = mk(0,0,0,          0,0,0,           7,0, 0,1,7,32'h1,       1,32'h2,       0,0);
    vecs[10] = mk(0,0,0,          0,0,0,           7,0, 0,1,7,32'h2,       1,32'h2,       0,0);
    vecs[11] = mk(0,0,0,          0,0,0,           7,0, 0,0,0,0,           0,0,           0,0);
    vecs[12] = mk(0,0,0,          1,0,32'hDEAD,    0,0, 0,0,0,0,           0,0,           0,0);
    vecs[13] = mk(0,0,0,          0,0,0,           0,0, 0,0,0,0,           0,0,           0,0);
    vecs[14] = mk(1,0,32'h55,     1,9,32'h99,      0,9, 0,0,0,0,           0,0,           0,0);
    vecs[15] = mk(0,0,0,          0,0,0,           0,9, 0,1,9,32'h99,      0,0,           1,32'h99);
    vecs[16] = mk(0,0,0,          0,0,0,           0,9, 0,0,0,0,           0,0,           0,0);

    #1;
    chk("reset.regWr", {31'd0, regWr}, 32'd0);
    chk("reset.stall", {31'd0, stall}, 32'd0);
    chk("reset.fwd1_hit", {31'd0, fwd1_hit}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].mv, vecs[i].mr, vecs[i].md, vecs[i].av, vecs[i].ar, vecs[i].ad,
            vecs[i].r1, vecs[i].r2);
      chk($sformatf("v%0d.stall", i),    {31'd0, stall},    {31'd0, vecs[i].eStall});
      chk($sformatf("v%0d.regWr", i),    {31'd0, regWr},    {31'd0, vecs[i].eWr});
      chk($sformatf("v%0d.RegW", i),     {27'd0, RegW},     {27'd0, vecs[i].eRegW});
      chk($sformatf("v%0d.WriteDat", i), WriteDat,          vecs[i].eDat);
      chk($sformatf("v%0d.fwd1_hit", i), {31'd0, fwd1_hit}, {31'd0, vecs[i].eH1});
      chk($sformatf("v%0d.fwd1_dat", i), fwd1_dat,          vecs[i].eD1);
      chk($sformatf("v%0d.fwd2_hit", i), {31'd0, fwd2_hit}, {31'd0, vecs[i].eH2});
      chk($sformatf("v%0d.fwd2_dat", i), fwd2_dat,          vecs[i].eD2);
    end

    // Back-to-back dual offers fill to three entries and the third offer is dropped.
    drive(1, 1, 32'hA1, 1, 2, 32'hA2, 0, 0);
    chk("fill.c0.stall", {31'd0, stall}, 32'd0);
    drive(1, 3, 32'hA3, 1, 4, 32'hA4, 0, 0);
    chk("fill.c1.stall", {31'd0, stall}, 32'd0);
    chk("fill.c1.RegW", {27'd0, RegW}, 32'd1);
    drive(1, 5, 32'hA5, 1, 6, 32'hA6, 5, 6);
    chk("fill.c2.stall", {31'd0, stall}, 32'd1);
    chk("fill.c2.RegW", {27'd0, RegW}, 32'd2);
    drive(0, 0, 0, 0, 0, 0, 5, 6);
    chk("fill.c3.stall", {31'd0, stall}, 32'd0);
    chk("fill.c3.RegW", {27'd0, RegW}, 32'd3);
    chk("fill.c3.fwd1_hit", {31'd0, fwd1_hit}, 32'd0);
    chk("fill.c3.fwd2_hit", {31'd0, fwd2_hit}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("fill.c4.RegW", {27'd0, RegW}, 32'd4);
    chk("fill.c4.WriteDat", WriteDat, 32'hA4);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("fill.c5.regWr", {31'd0, regWr}, 32'd0);

    // Asynchronous reset with three entries pending discards them immediately.
    drive(1, 1, 32'hB1, 1, 2, 32'hB2, 0, 0);
    drive(1, 3, 32'hB3, 1, 3, 32'hB4, 3, 0);
    drive(0, 0, 0, 0, 0, 0, 3, 0);
    chk("rst.pre.stall", {31'd0, stall}, 32'd1);
    chk("rst.pre.regWr", {31'd0, regWr}, 32'd1);
    chk("rst.pre.fwd1_dat", fwd1_dat, 32'hB4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst.now.regWr", {31'd0, regWr}, 32'd0);
    chk("rst.now.stall", {31'd0, stall}, 32'd0);
    chk("rst.now.fwd1_hit", {31'd0, fwd1_hit}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 3, 0);
      chk($sformatf("rst.after%0d.regWr", k), {31'd0, regWr}, 32'd0);
      chk($sformatf("rst.after%0d.fwd1_hit", k), {31'd0, fwd1_hit}, 32'd0);
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
